demux_1to2_stream: RTL and testbench

//   Registered 1-to-2 stream demultiplexer; the inverse of the 2:1 mux.

---
 rtl/demux_1to2_stream.sv | 93 +++++++++
 tb/tb_demux_1to2_stream.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to2_stream
// Purpose  : Registered 1-to-2 stream demultiplexer with a FIFO per channel.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to2_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       I,
    input  logic                   S,
    input  logic                   I_valid,
    output logic                   I_ready,
    output logic [WIDTH-1:0]       Y0,
    output logic                   Y0_valid,
    input  logic                   Y0_ready,
    output logic [WIDTH-1:0]       Y1,
    output logic                   Y1_valid,
    input  logic                   Y1_ready,
    output logic [$clog2(DEPTH):0] Y0_count,
    output logic [$clog2(DEPTH):0] Y1_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [1:0]       w_full;
    logic [1:0]       w_valid;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_ready;
    logic [WIDTH-1:0] w_head  [2];
    logic [CW-1:0]    w_count [2];

    assign w_ready = {Y1_ready, Y0_ready};
    // Admission looks only at the selected channel's occupancy, never at a pop.
    assign I_ready = ~w_full[S];

    generate
        for (genvar n = 0; n < 2; n++) begin : g_ch
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [AW-1:0]    r_wr;
            logic [AW-1:0]    r_rd;
            logic [CW-1:0]    r_cnt;

            assign w_full[n]  = (r_cnt == c_FULL);
            assign w_valid[n] = (r_cnt != '0);
            assign w_push[n]  = I_valid & ~w_full[n] & (S == 1'(n));
            assign w_pop[n]   = w_valid[n] & w_ready[n];
            assign w_head[n]  = w_valid[n] ? r_mem[r_rd] : '0;
            assign w_count[n] = r_cnt;

            always_ff @(posedge clk) begin
                if (!rst && w_push[n]) begin
                    r_mem[r_wr] <= I;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr  <= '0;
                    r_rd  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_push[n]) begin
                        r_wr <= r_wr + 1'b1;
                    end
                    if (w_pop[n]) begin
                        r_rd <= r_rd + 1'b1;
                    end
                    case ({w_push[n], w_pop[n]})
                        2'b10:   r_cnt <= r_cnt + 1'b1;
                        2'b01:   r_cnt <= r_cnt - 1'b1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    assign Y0       = w_head[0];
    assign Y1       = w_head[1];
    assign Y0_valid = w_valid[0];
    assign Y1_valid = w_valid[1];
    assign Y0_count = w_count[0];
    assign Y1_count = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_demux_1to2_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to2_stream
// Purpose  : Self-checking bench for demux_1to2_stream (vectors + random model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to2_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] I;
    logic             S;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] Y0, Y1;
    logic             Y0_valid, Y1_valid;
    logic             Y0_ready, Y1_ready;
    logic [2:0]       Y0_count, Y1_count;

    demux_1to2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .I(I), .S(S), .I_valid(I_valid), .I_ready(I_ready),
        .Y0(Y0), .Y0_valid(Y0_valid), .Y0_ready(Y0_ready),
        .Y1(Y1), .Y1_valid(Y1_valid), .Y1_ready(Y1_ready),
        .Y0_count(Y0_count), .Y1_count(Y1_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: each channel is just an ordered queue bounded at DEPTH.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] out0[$];
    logic [7:0] out1[$];

    typedef struct {
        bit         rst;
        logic [7:0] din;
        bit         sel;
        bit         vld;
        bit         r0;
        bit         r1;
        bit         chk_ir;
        bit         ir;
        logic [7:0] y0;
        bit         v0;
        logic [7:0] y1;
        bit         v1;
        int         c0;
        int         c1;
    } vec_t;

    vec_t tbl [11];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge, updating the queue model from the inputs seen at that edge.
    task automatic cycle();
        bit acc, p0, p1;
        acc = I_valid && ((S ? q1.size() : q0.size()) < DEPTH);
        p0  = Y0_ready && (q0.size() > 0);
        p1  = Y1_ready && (q1.size() > 0);
        if (!rst && Y0_valid && Y0_ready) out0.push_back(Y0);
        if (!rst && Y1_valid && Y1_ready) out1.push_back(Y1);
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (acc) begin
                if (S) q1.push_back(I);
                else   q0.push_back(I);
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".y0_valid"}, int'(Y0_valid), int'(q0.size() != 0));
        cmp({tag, ".y1_valid"}, int'(Y1_valid), int'(q1.size() != 0));
        cmp({tag, ".y0"},       int'(Y0), (q0.size() != 0) ? int'(q0[0]) : 0);
        cmp({tag, ".y1"},       int'(Y1), (q1.size() != 0) ? int'(q1[0]) : 0);
        cmp({tag, ".y0_count"}, int'(Y0_count), q0.size());
        cmp({tag, ".y1_count"}, int'(Y1_count), q1.size());
        cmp({tag, ".i_ready"},  int'(I_ready), int'((S ? q1.size() : q0.size()) < DEPTH));
    endtask

    task automatic drive(input bit r, input logic [7:0] d, input bit s, input bit v,
                         input bit r0, input bit r1);
        rst = r; I = d; S = s; I_valid = v; Y0_ready = r0; Y1_ready = r1;
    endtask

    initial begin
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        //             rst din   sel vld r0 r1 chk ir  y0    v0 y1    v1 c0 c1
        tbl[0]  = '{1'b1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{1'b0, 8'hA5, 0, 1, 0, 0, 1, 1, 8'hA5, 1, 8'h00, 0, 1, 0};
        tbl[2]  = '{1'b1, 8'h00, 0, 0, 0, 0, 1, 1, 8'h00, 0, 8'h00, 0, 0, 0};
        tbl[3]  = '{1'b0, 8'h01, 0, 1, 0, 0, 1, 1, 8'h01, 1, 8'h00, 0, 1, 0};
        tbl[4]  = '{1'b0, 8'h02, 0, 1, 0, 0, 1, 1, 8'h01, 1, 8'h00, 0, 2, 0};
        tbl[5]  = '{1'b0, 8'h03, 0, 1, 0, 0, 1, 1, 8'h01, 1, 8'h00, 0, 3, 0};
        tbl[6]  = '{1'b0, 8'h04, 0, 1, 0, 0, 1, 1, 8'h01, 1, 8'h00, 0, 4, 0};
        tbl[7]  = '{1'b0, 8'h77, 0, 1, 0, 0, 1, 0, 8'h01, 1, 8'h00, 0, 4, 0};
        tbl[8]  = '{1'b0, 8'h77, 1, 1, 0, 0, 1, 1, 8'h01, 1, 8'h77, 1, 4, 1};
        tbl[9]  = '{1'b0, 8'h05, 0, 1, 1, 0, 1, 0, 8'h02, 1, 8'h77, 1, 3, 1};
        tbl[10] = '{1'b0, 8'h05, 0, 1, 0, 0, 1, 1, 8'h02, 1, 8'h77, 1, 4, 1};

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].din, tbl[i].sel, tbl[i].vld, tbl[i].r0, tbl[i].r1);
            #1;
            if (tbl[i].chk_ir) cmp($sformatf("vec%0d.i_ready", i), int'(I_ready), int'(tbl[i].ir));
            cycle();
            cmp($sformatf("vec%0d.y0", i),       int'(Y0),       int'(tbl[i].y0));
            cmp($sformatf("vec%0d.y0_valid", i), int'(Y0_valid), int'(tbl[i].v0));
            cmp($sformatf("vec%0d.y1", i),       int'(Y1),       int'(tbl[i].y1));
            cmp($sformatf("vec%0d.y1_valid", i), int'(Y1_valid), int'(tbl[i].v1));
            cmp($sformatf("vec%0d.y0_count", i), int'(Y0_count), tbl[i].c0);
            cmp($sformatf("vec%0d.y1_count", i), int'(Y1_count), tbl[i].c1);
        end

        // Steady alternating stream with both consumers always ready.
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        out0.delete(); out1.delete();
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drive(1'b0, 8'(8'h10 + i), i[0], 1'b1, 1'b1, 1'b1);
            else        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
            cycle();
            check_model("stream");
            cmp("stream.c0_le1", int'(Y0_count <= 3'd1), 1);
            cmp("stream.c1_le1", int'(Y1_count <= 3'd1), 1);
        end
        cmp("stream.n0", out0.size(), 5);
        cmp("stream.n1", out1.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < out0.size()) cmp($sformatf("stream.ch0[%0d]", i), int'(out0[i]), 8'h10 + 2*i);
            if (i < out1.size()) cmp($sformatf("stream.ch1[%0d]", i), int'(out1[i]), 8'h11 + 2*i);
        end

        // Pointer wrap: nine beats through channel 1.
        out0.delete(); out1.delete();
        for (int i = 0; i < 11; i++) begin
            if (i < 9) drive(1'b0, 8'(8'h30 + i), 1'b1, 1'b1, 1'b0, 1'b1);
            else       drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
            cycle();
            check_model("wrap");
        end
        cmp("wrap.n1", out1.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < out1.size()) cmp($sformatf("wrap.ch1[%0d]", i), int'(out1[i]), 8'h30 + i);
        cmp("wrap.y1_count", int'(Y1_count), 0);

        // Reset mid-stream with both channels holding 3 beats.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'(8'h50 + i), i[0], 1'b1, 1'b0, 1'b0);
            cycle();
        end
        cmp("prerst.y0_count", int'(Y0_count), 3);
        cmp("prerst.y1_count", int'(Y1_count), 3);
        drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        check_model("rst");
        cmp("rst.y0_count", int'(Y0_count), 0);
        cmp("rst.y1_count", int'(Y1_count), 0);
        cmp("rst.y0", int'(Y0), 0);
        cmp("rst.y1", int'(Y1), 0);
        cmp("rst.i_ready_s0", int'(I_ready), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        cmp("rst.i_ready_s1", int'(I_ready), 1);

        // Randomized traffic: fill-heavy first half, drain-heavy second half.
        for (int k = 0; k < 400; k++) begin
            if (!(I_valid && !I_ready)) begin
                I       = 8'($urandom);
                S       = 1'($urandom);
                I_valid = ($urandom_range(0, 3) != 0);
            end
            Y0_ready = ($urandom_range(0, 99) < ((k < 200) ? 30 : 70));
            Y1_ready = ($urandom_range(0, 99) < ((k < 200) ? 30 : 70));
            rst      = ($urandom_range(0, 63) == 0);
            cycle();
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
